// File: rtl/regfile_write_buffer_if.sv
// Bus bundle between the execute/memory stages, the write buffer and the
// register file.
//   master : request producer / register-file side (drives requests, grant,
//            snoop addresses; observes write port, forwarding, occupancy)
//   slave  : the write buffer itself
interface regfile_write_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
);
  logic              InValid;
  logic              InReady;
  logic [4:0]        InRegister;
  logic [31:0]       InData;
  logic              PortGrant;
  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [31:0]       WriteData;
  logic [4:0]        ReadRegister1;
  logic [4:0]        ReadRegister2;
  logic              FwdHit1;
  logic              FwdHit2;
  logic [31:0]       FwdData1;
  logic [31:0]       FwdData2;
  logic [PTR_W:0]    Count;

  modport master (
    output InValid, InRegister, InData, PortGrant, ReadRegister1, ReadRegister2,
    input  InReady, RegWrite, WriteRegister, WriteData,
    input  FwdHit1, FwdHit2, FwdData1, FwdData2, Count
  );

  modport slave (
    input  InValid, InRegister, InData, PortGrant, ReadRegister1, ReadRegister2,
    output InReady, RegWrite, WriteRegister, WriteData,
    output FwdHit1, FwdHit2, FwdData1, FwdData2, Count
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order write buffer in front of the register file's single write port.
// Requests are queued over a valid/ready handshake, drained one per granted
// cycle, and snooped by both read ports (youngest pending value wins).
// Writes to $0 are accepted and dropped.
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : request in (InValid/InReady/InRegister/InData),
//                  write port out (PortGrant/RegWrite/WriteRegister/WriteData),
//                  snoop (ReadRegister1/2 -> FwdHit1/2, FwdData1/2), Count
// Build option: define WBUF_COALESCE_EN to merge a request into the youngest
// queued entry when it targets the same register.
module regfile_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  regfile_write_buffer_if.slave bus
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [4:0]       entryReg  [DEPTH];
  logic [31:0]      entryData [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] youngPtr;
  logic [CNT_W-1:0] count;

  logic notEmpty;
  logic pop;
  logic matchYoung;
  logic inReady;
  logic accept;
  logic push;
  logic coalesce;

  // Handshake and drain decisions
  always_comb begin
    notEmpty = (count != '0);
    pop      = notEmpty && bus.PortGrant;
    youngPtr = wrPtr - PTR_W'(1);
`ifdef WBUF_COALESCE_EN
    // The youngest entry can absorb the request unless it is the head leaving now.
    matchYoung = notEmpty && entryValid[youngPtr] &&
                 (entryReg[youngPtr] == bus.InRegister) &&
                 !((count == CNT_W'(1)) && pop);
`else
    matchYoung = 1'b0;
`endif
    inReady  = (count < FULL) || pop ||
               (bus.InValid && (bus.InRegister != 5'd0) && matchYoung);
    accept   = bus.InValid && inReady;
    push     = accept && (bus.InRegister != 5'd0) && !matchYoung;
    coalesce = accept && (bus.InRegister != 5'd0) && matchYoung;
  end

  assign bus.InReady       = inReady;
  assign bus.RegWrite      = pop;
  assign bus.WriteRegister = notEmpty ? entryReg[rdPtr]  : 5'd0;
  assign bus.WriteData     = notEmpty ? entryData[rdPtr] : 32'd0;
  assign bus.Count         = count;

  // Pointers, occupancy and valid bits
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      if (pop) begin
        entryValid[rdPtr] <= 1'b0;
        rdPtr             <= rdPtr + PTR_W'(1);
      end
      // Placed after the pop so a full-queue push/pop on the same slot leaves it valid.
      if (push) begin
        entryValid[wrPtr] <= 1'b1;
        wrPtr             <= wrPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; contents are qualified by entryValid/count
  always_ff @(posedge Clk) begin
    if (push) begin
      entryReg[wrPtr]  <= bus.InRegister;
      entryData[wrPtr] <= bus.InData;
    end else if (coalesce) begin
      entryData[youngPtr] <= bus.InData;
    end
  end

  // Snoop: walk oldest to youngest so the youngest match is the one left standing
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = '0;
    bus.FwdHit1  = 1'b0;
    bus.FwdHit2  = 1'b0;
    bus.FwdData1 = 32'd0;
    bus.FwdData2 = 32'd0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PTR_W'(i);
      if (entryValid[idx] && (bus.ReadRegister1 != 5'd0) &&
          (entryReg[idx] == bus.ReadRegister1)) begin
        bus.FwdHit1  = 1'b1;
        bus.FwdData1 = entryData[idx];
      end
      if (entryValid[idx] && (bus.ReadRegister2 != 5'd0) &&
          (entryReg[idx] == bus.ReadRegister2)) begin
        bus.FwdHit2  = 1'b1;
        bus.FwdData2 = entryData[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic Clk;
  logic Reset_n;
  int   nVec;
  int   nErr;
  ent_t q[$];

  regfile_write_buffer_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

  regfile_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model (queue of pending writes) ----------------
  function automatic bit mdlPop();
    return (q.size() != 0) && (bus.PortGrant == 1'b1);
  endfunction

  function automatic bit mdlCoalesce(input logic [4:0] r, input bit pop);
`ifdef WBUF_COALESCE_EN
    if (r == 5'd0 || q.size() == 0) return 1'b0;
    if (q.size() == 1 && pop) return 1'b0;
    return q[$].r == r;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit mdlReady();
    bit pop;
    pop = mdlPop();
    return (q.size() < DEPTH) || pop ||
           (bus.InValid == 1'b1 && mdlCoalesce(bus.InRegister, pop));
  endfunction

  // {hit, data} for the youngest queued write to r
  function automatic logic [32:0] mdlFwd(input logic [4:0] r);
    logic [32:0] res;
    res = 33'd0;
    if (r != 5'd0)
      foreach (q[i]) if (q[i].r == r) res = {1'b1, q[i].d};
    return res;
  endfunction

  task automatic mdlEdge();
    bit pop;
    bit rdy;
    bit co;
    ent_t e;
    if (Reset_n !== 1'b1) begin
      q.delete();
      return;
    end
    pop = mdlPop();
    co  = mdlCoalesce(bus.InRegister, pop);
    rdy = mdlReady();
    if (pop) void'(q.pop_front());
    if (bus.InValid == 1'b1 && rdy && bus.InRegister != 5'd0) begin
      if (co) q[q.size()-1].d = bus.InData;
      else begin
        e.r = bus.InRegister;
        e.d = bus.InData;
        q.push_back(e);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic setIn(input bit v, input logic [4:0] r, input logic [31:0] d, input bit g);
    bus.InValid    = v;
    bus.InRegister = r;
    bus.InData     = d;
    bus.PortGrant  = g;
  endtask

  // One clock: model follows the DUT at the edge; returns just after the next negedge
  task automatic tick();
    @(posedge Clk);
    mdlEdge();
    @(negedge Clk);
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset_n = 1'b0;
    setIn(1'b0, 5'd0, 32'd0, 1'b0);
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;
    q.delete();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    doReset();
    bus.ReadRegister1 = 5'd5;
    bus.ReadRegister2 = 5'd6;
    #1;
    nVec++; if (bus.Count !== 3'd0) begin nErr++; $display("FAIL reset_count got %0d want 0", bus.Count); end
    nVec++; if (bus.RegWrite !== 1'b0) begin nErr++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
    nVec++; if (bus.InReady !== 1'b1) begin nErr++; $display("FAIL reset_inready got %b want 1", bus.InReady); end
    nVec++; if ({bus.FwdHit1, bus.FwdHit2} !== 2'b00) begin nErr++; $display("FAIL reset_fwdhit got %b want 00", {bus.FwdHit1, bus.FwdHit2}); end
    nVec++; if ({bus.WriteRegister, bus.WriteData} !== 37'd0) begin nErr++; $display("FAIL reset_wport got %0d/%h want 0/0", bus.WriteRegister, bus.WriteData); end
    nVec++; if ({bus.FwdData1, bus.FwdData2} !== 64'd0) begin nErr++; $display("FAIL reset_fwddata got %h/%h want 0/0", bus.FwdData1, bus.FwdData2); end
  endtask

  task automatic test_single();
    doReset();
    setIn(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b1);
    #1;
    nVec++; if (bus.RegWrite !== 1'b1) begin nErr++; $display("FAIL single_regwrite got %b want 1", bus.RegWrite); end
    nVec++; if (bus.WriteRegister !== 5'd5) begin nErr++; $display("FAIL single_wreg got %0d want 5", bus.WriteRegister); end
    nVec++; if (bus.WriteData !== 32'hDEADBEEF) begin nErr++; $display("FAIL single_wdata got %h want deadbeef", bus.WriteData); end
    tick();
    #1;
    nVec++; if (bus.Count !== 3'd0) begin nErr++; $display("FAIL single_count got %0d want 0", bus.Count); end
    nVec++; if (bus.RegWrite !== 1'b0) begin nErr++; $display("FAIL single_idle got %b want 0", bus.RegWrite); end
  endtask

  task automatic test_fill_drain();
    doReset();
    for (int i = 1; i <= 4; i++) begin
      setIn(1'b1, 5'(i), 32'(i * 'h11), 1'b0);
      tick();
    end
    setIn(1'b1, 5'd9, 32'h99, 1'b0);
    #1;
    nVec++; if (bus.Count !== 3'd4) begin nErr++; $display("FAIL fill_count got %0d want 4", bus.Count); end
    nVec++; if (bus.InReady !== 1'b0) begin nErr++; $display("FAIL fill_inready got %b want 0", bus.InReady); end
    tick();
    #1;
    nVec++; if (bus.Count !== 3'd4 || bus.WriteRegister !== 5'd1) begin nErr++; $display("FAIL fill_hold got %0d/r%0d want 4/r1", bus.Count, bus.WriteRegister); end
    bus.PortGrant = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      nVec++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(k) || bus.WriteData !== 32'(k * 'h11))
        begin nErr++; $display("FAIL drain_%0d got %b/r%0d/%h want 1/r%0d/%h", k, bus.RegWrite, bus.WriteRegister, bus.WriteData, k, k * 'h11); end
      if (k == 1) begin
        nVec++; if (bus.InReady !== 1'b1) begin nErr++; $display("FAIL drain_ready got %b want 1", bus.InReady); end
      end
      tick();
      if (k == 1) begin
        #1;
        nVec++; if (bus.Count !== 3'd4) begin nErr++; $display("FAIL drain_pushpop_count got %0d want 4", bus.Count); end
        setIn(1'b0, 5'd0, 32'd0, 1'b1);
      end
    end
    #1;
    nVec++; if (bus.WriteRegister !== 5'd9 || bus.WriteData !== 32'h99 || bus.Count !== 3'd1)
      begin nErr++; $display("FAIL drain_fifth got r%0d/%h/%0d want r9/99/1", bus.WriteRegister, bus.WriteData, bus.Count); end
    tick();
    #1;
    nVec++; if (bus.Count !== 3'd0) begin nErr++; $display("FAIL drain_empty got %0d want 0", bus.Count); end
  endtask

  task automatic test_forward();
    doReset();
    setIn(1'b1, 5'd7, 32'hA, 1'b0);
    tick();
    setIn(1'b1, 5'd7, 32'hB, 1'b0);
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b0);
    bus.ReadRegister1 = 5'd7;
    bus.ReadRegister2 = 5'd8;
    #1;
    nVec++; if (bus.FwdHit1 !== 1'b1 || bus.FwdData1 !== 32'hB) begin nErr++; $display("FAIL fwd_hit1 got %b/%h want 1/b", bus.FwdHit1, bus.FwdData1); end
    nVec++; if (bus.FwdHit2 !== 1'b0 || bus.FwdData2 !== 32'd0) begin nErr++; $display("FAIL fwd_miss2 got %b/%h want 0/0", bus.FwdHit2, bus.FwdData2); end
    // The head still forwards until the edge that writes it
    bus.ReadRegister2 = 5'd7;
    bus.PortGrant = 1'b1;
    #1;
    nVec++; if (bus.FwdHit2 !== 1'b1 || bus.FwdData2 !== 32'hB) begin nErr++; $display("FAIL fwd_hit2 got %b/%h want 1/b", bus.FwdHit2, bus.FwdData2); end
  endtask

  task automatic test_zero();
    doReset();
    setIn(1'b1, 5'd0, 32'h1234, 1'b1);
    #1;
    nVec++; if (bus.InReady !== 1'b1) begin nErr++; $display("FAIL zero_ready got %b want 1", bus.InReady); end
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b1);
    bus.ReadRegister1 = 5'd0;
    #1;
    nVec++; if (bus.Count !== 3'd0 || bus.RegWrite !== 1'b0) begin nErr++; $display("FAIL zero_drop got %0d/%b want 0/0", bus.Count, bus.RegWrite); end
    nVec++; if (bus.FwdHit1 !== 1'b0) begin nErr++; $display("FAIL zero_fwd got %b want 0", bus.FwdHit1); end
  endtask

  task automatic test_back_to_back_reset();
    doReset();
    for (int i = 1; i <= 4; i++) begin
      setIn(1'b1, 5'(i), $urandom, 1'b0);
      tick();
    end
    setIn(1'b1, 5'd10, 32'hCAFE, 1'b1);
    tick();
    #1;
    nVec++; if (bus.Count !== 3'd4 || bus.WriteRegister !== 5'd2) begin nErr++; $display("FAIL b2b_count got %0d/r%0d want 4/r2", bus.Count, bus.WriteRegister); end
    bus.ReadRegister1 = 5'd10;
    bus.ReadRegister2 = 5'd3;
    #1;
    Reset_n = 1'b0;
    q.delete();
    #1;
    nVec++; if (bus.Count !== 3'd0 || bus.RegWrite !== 1'b0) begin nErr++; $display("FAIL async_reset got %0d/%b want 0/0", bus.Count, bus.RegWrite); end
    nVec++; if ({bus.FwdHit1, bus.FwdHit2} !== 2'b00) begin nErr++; $display("FAIL async_fwd got %b want 00", {bus.FwdHit1, bus.FwdHit2}); end
    @(negedge Clk);
    setIn(1'b0, 5'd0, 32'd0, 1'b0);
    Reset_n = 1'b1;
  endtask

  task automatic test_coalesce();
    doReset();
    setIn(1'b1, 5'd3, 32'd1, 1'b0);
    tick();
    setIn(1'b1, 5'd3, 32'd2, 1'b0);
    tick();
    setIn(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
`ifdef WBUF_COALESCE_EN
    nVec++; if (bus.Count !== 3'd1 || bus.WriteData !== 32'd2) begin nErr++; $display("FAIL coal_merge got %0d/%h want 1/2", bus.Count, bus.WriteData); end
`else
    nVec++; if (bus.Count !== 3'd2 || bus.WriteData !== 32'd1) begin nErr++; $display("FAIL coal_off got %0d/%h want 2/1", bus.Count, bus.WriteData); end
    bus.PortGrant = 1'b1;
    tick();
    #1;
    nVec++; if (bus.WriteRegister !== 5'd3 || bus.WriteData !== 32'd2) begin nErr++; $display("FAIL coal_order got r%0d/%h want r3/2", bus.WriteRegister, bus.WriteData); end
`endif
  endtask

  task automatic test_random();
    logic [32:0] f1;
    logic [32:0] f2;
    doReset();
    for (int n = 0; n < 400; n++) begin
      setIn($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1);
      bus.ReadRegister1 = 5'($urandom_range(0, 7));
      bus.ReadRegister2 = 5'($urandom_range(0, 7));
      #1;
      f1 = mdlFwd(bus.ReadRegister1);
      f2 = mdlFwd(bus.ReadRegister2);
      nVec++; if (bus.Count !== 3'(q.size())) begin nErr++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, bus.Count, q.size()); end
      nVec++; if (bus.InReady !== mdlReady()) begin nErr++; $display("FAIL rnd_ready[%0d] got %b want %b", n, bus.InReady, mdlReady()); end
      nVec++; if (bus.RegWrite !== mdlPop()) begin nErr++; $display("FAIL rnd_regwrite[%0d] got %b want %b", n, bus.RegWrite, mdlPop()); end
      if (q.size() != 0) begin
        nVec++; if (bus.WriteRegister !== q[0].r || bus.WriteData !== q[0].d)
          begin nErr++; $display("FAIL rnd_head[%0d] got r%0d/%h want r%0d/%h", n, bus.WriteRegister, bus.WriteData, q[0].r, q[0].d); end
      end else begin
        nVec++; if ({bus.WriteRegister, bus.WriteData} !== 37'd0) begin nErr++; $display("FAIL rnd_empty[%0d] got r%0d/%h want 0/0", n, bus.WriteRegister, bus.WriteData); end
      end
      nVec++; if ({bus.FwdHit1, bus.FwdData1} !== f1) begin nErr++; $display("FAIL rnd_fwd1[%0d] got %b/%h want %b/%h", n, bus.FwdHit1, bus.FwdData1, f1[32], f1[31:0]); end
      nVec++; if ({bus.FwdHit2, bus.FwdData2} !== f2) begin nErr++; $display("FAIL rnd_fwd2[%0d] got %b/%h want %b/%h", n, bus.FwdHit2, bus.FwdData2, f2[32], f2[31:0]); end
      tick();
    end
  endtask

  initial begin
    nVec    = 0;
    nErr    = 0;
    Reset_n = 1'b0;
    setIn(1'b0, 5'd0, 32'd0, 1'b0);
    bus.ReadRegister1 = 5'd0;
    bus.ReadRegister2 = 5'd0;
    test_reset();
    test_single();
    test_fill_drain();
    test_forward();
    test_zero();
    test_back_to_back_reset();
    test_coalesce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
